pc_branch_unit: RTL and testbench
=================================

// Module: pc_branch_unit
// PURPOSE
//  Per-thread program-counter / branch unit for a compute-core thread. Computes next_pc once per
//  instruction in EXECUTE, holds NZP flags written in UPDATE, and adds relative branches plus a
//  CALL/RET return-address stack. Instantiated once per thread next to that thread's ALU/LSU.
// PARAMETERS
//  DATA_MEM_DATA_BITS     8  width of decoded_immediate and alu_out
//  PROGRAM_MEM_ADDR_BITS  8  width of current_pc / next_pc / stack entries
//  STACK_DEPTH            4  return-address stack entries, legal range 1..16
//  (local) SP_BITS = $clog2(STACK_DEPTH+1)
// PORTS
//  clk                       in   1       core clock; all state updates on posedge
//  reset                     in   1       synchronous, active-high
//  core_state                in   3       core FSM state: EXECUTE=3'b101, UPDATE=3'b110
//  decoded_nzp               in   3       branch condition mask {N,Z,P}
//  decoded_immediate         in   DMDB    branch/call target or signed relative offset
//  decoded_nzp_write_enable  in   1       latch alu_out[2:0] into NZP during UPDATE
//  decoded_pc_mux            in   1       1 = conditional branch instruction
//  decoded_pc_rel            in   1       branch target relative (1) or absolute (0)
//  decoded_call              in   1       CALL: push return address, jump absolute
//  decoded_ret               in   1       RET: pop return address
//  alu_out                   in   DMDB    ALU result; [2:0] carries the {N,Z,P} compare result
//  current_pc                in   PMAB    PC of the instruction in flight
//  next_pc                   out  PMAB    PC of the following instruction
//  stack_depth               out  SP_BITS valid entries on the return stack
//  stack_overflow            out  1       sticky: CALL attempted with stack full
//  stack_underflow           out  1       sticky: RET attempted with stack empty
// BEHAVIOUR
//  - Reset: next_pc=0, nzp=0, stack_depth=0, both sticky flags=0, stack contents don't-care.
//    Reset mid-instruction discards everything. Only reset clears the sticky flags.
//  - The unit acts only when core_state==EXECUTE (next_pc/stack) or UPDATE (nzp). In other
//    states every register holds.
//  - EXECUTE priority: decoded_ret > decoded_call > decoded_pc_mux > sequential. Exactly one
//    action per instruction.
//  - seq = current_pc+1, modulo 2^PMAB. Wrapping from all-ones to 0 is legal.
//  - Absolute target: decoded_immediate zero-extended or truncated to PMAB.
//  - Relative target: seq + sign-extended decoded_immediate, modulo 2^PMAB.
//  - Branch: taken if (nzp & decoded_nzp)!=0; next_pc = target (rel/abs by decoded_pc_rel).
//    Not taken: next_pc=seq. A mask of 3'b000 never branches; 3'b111 always branches.
//  - CALL, not full: stack[depth]<=seq, depth+1, next_pc=absolute target.
//    CALL, full: no push, no jump, next_pc=seq, stack_overflow<=1.
//  - RET, not empty: next_pc=stack[depth-1], depth-1.
//    RET, empty: next_pc=seq, depth stays 0, stack_underflow<=1.
//  - UPDATE: if decoded_nzp_write_enable then nzp<=alu_out[2:0]. A branch in EXECUTE always
//    uses the NZP latched by an earlier instruction's UPDATE.
//  - Latency: next_pc is valid on the cycle after the EXECUTE edge and holds until the next
//    EXECUTE. stack_depth and the flags update on the same edge as next_pc.
//  - The stack is LIFO with no wrap: depth saturates at STACK_DEPTH and at 0, as above.
// CONFIGURATION
//  PC_BRANCH_CNT_EN defined: adds output branch_taken_count [15:0], reset to 0. It increments
//    by 1 on each EXECUTE that redirects (taken branch, successful CALL, successful RET) and
//    saturates at 16'hFFFF.
//  PC_BRANCH_CNT_EN undefined: the port and counter are absent. All other behaviour is
//    identical.
// TESTING
//  1. Reset, EXECUTE with no decode flags and current_pc=8'h05 -> next_pc=8'h06;
//     current_pc=8'hFF -> next_pc=8'h00.
//  2. UPDATE with nzp_we=1 and alu_out=8'h02, then EXECUTE with pc_mux=1, nzp=3'b010,
//     imm=8'h40, rel=0 -> next_pc=8'h40. Same with mask 3'b101 -> next_pc=current_pc+1.
//  3. Relative branch taken, current_pc=8'h10, imm=8'hFC -> next_pc=8'h0D;
//     imm=8'h05 -> next_pc=8'h16.
//  4. With STACK_DEPTH=4: CALLs from pc 1,2,3,4 with imm 8'h80 -> depth=4, next_pc=8'h80.
//     A 5th CALL from pc=8'h20 -> next_pc=8'h21, stack_overflow=1.
//     Four RETs -> next_pc 5,4,3,2.
//  5. RET with stack empty and current_pc=8'h30 -> next_pc=8'h31, stack_underflow=1, depth=0.
//     The flag stays set until reset.
//  6. CALL and RET asserted together at depth=1 with top=8'h09 -> RET wins: next_pc=8'h09,
//     depth=0. Reset asserted during EXECUTE -> all outputs return to 0 on that edge.

Source files
------------

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: per-thread next-PC computation, NZP flag register and
// CALL/RET return-address stack for one compute-core thread.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   core_state                 core FSM state (EXECUTE=3'b101, UPDATE=3'b110)
//   decoded_nzp                branch condition mask {N,Z,P}
//   decoded_immediate          branch/call target or signed relative offset
//   decoded_nzp_write_enable   latch alu_out[2:0] into NZP during UPDATE
//   decoded_pc_mux             conditional branch instruction
//   decoded_pc_rel             relative (1) or absolute (0) branch target
//   decoded_call / decoded_ret CALL (push + absolute jump) / RET (pop)
//   alu_out                    ALU result, [2:0] = {N,Z,P}
//   current_pc                 PC of the instruction in flight
//   next_pc                    PC of the following instruction
//   stack_depth                valid return-stack entries
//   stack_overflow/underflow   sticky error flags, cleared only by reset
//   branch_taken_count         redirect counter (only with PC_BRANCH_CNT_EN)
//
// Optional feature macro: PC_BRANCH_CNT_EN

module pc_branch_unit #(
    parameter int DATA_MEM_DATA_BITS    = 8,
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int STACK_DEPTH           = 4,
    localparam int SP_BITS = $clog2(STACK_DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [2:0]                       decoded_nzp,
    input  logic [DATA_MEM_DATA_BITS-1:0]    decoded_immediate,
    input  logic                             decoded_nzp_write_enable,
    input  logic                             decoded_pc_mux,
    input  logic                             decoded_pc_rel,
    input  logic                             decoded_call,
    input  logic                             decoded_ret,
    input  logic [DATA_MEM_DATA_BITS-1:0]    alu_out,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] next_pc,
    output logic [SP_BITS-1:0]               stack_depth,
    output logic                             stack_overflow,
`ifdef PC_BRANCH_CNT_EN
    output logic                             stack_underflow,
    output logic [15:0]                      branch_taken_count
`else
    output logic                             stack_underflow
`endif
);

    localparam int PMAB = PROGRAM_MEM_ADDR_BITS;
    localparam int DMDB = DATA_MEM_DATA_BITS;
    localparam int IDX_BITS = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int ENTRIES = 2 ** IDX_BITS;

    localparam logic [2:0] ST_EXECUTE = 3'b101;
    localparam logic [2:0] ST_UPDATE  = 3'b110;

    localparam logic [SP_BITS-1:0] SP_ONE  = SP_BITS'(1);
    localparam logic [SP_BITS-1:0] SP_ZERO = '0;
    localparam logic [SP_BITS-1:0] SP_FULL = SP_BITS'(STACK_DEPTH);
    localparam logic [PMAB-1:0]    PC_ONE  = PMAB'(1);

    logic [PMAB-1:0]    pc_q, pc_d;
    logic [2:0]         nzp_q;
    logic [SP_BITS-1:0] sp_q, sp_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               push;
    logic               redirect;

    // Array is rounded up to a power of two so the index width matches
    // exactly; entries at or above STACK_DEPTH are never written.
    logic [PMAB-1:0]     stack_q [ENTRIES];
    logic [IDX_BITS-1:0] push_idx;
    logic [IDX_BITS-1:0] pop_idx;

    logic [PMAB-1:0] seq;
    logic [PMAB-1:0] imm_abs;
    logic [PMAB-1:0] imm_sext;
    logic [PMAB-1:0] rel_tgt;

    logic is_exec;
    logic is_upd;

    // Only alu_out[2:0] is meaningful here; wider immediates are truncated.
    logic unused_bits;
    assign unused_bits = ^{alu_out, decoded_immediate};

    assign is_exec = (core_state == ST_EXECUTE);
    assign is_upd  = (core_state == ST_UPDATE);

    assign seq      = current_pc + PC_ONE;
    assign push_idx = sp_q[IDX_BITS-1:0];
    assign pop_idx  = IDX_BITS'(sp_q - SP_ONE);

    generate
        if (DMDB >= PMAB) begin : g_imm_trunc
            // Truncation is exact for modulo-2^PMAB arithmetic.
            assign imm_abs  = decoded_immediate[PMAB-1:0];
            assign imm_sext = decoded_immediate[PMAB-1:0];
        end else begin : g_imm_ext
            assign imm_abs  = {{(PMAB-DMDB){1'b0}}, decoded_immediate};
            assign imm_sext = {{(PMAB-DMDB){decoded_immediate[DMDB-1]}},
                               decoded_immediate};
        end
    endgenerate

    assign rel_tgt = seq + imm_sext;

    // One action per EXECUTE, priority RET > CALL > branch > sequential.
    always_comb begin
        pc_d     = pc_q;
        sp_d     = sp_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        push     = 1'b0;
        redirect = 1'b0;
        if (is_exec) begin
            if (decoded_ret) begin
                if (sp_q == SP_ZERO) begin
                    pc_d  = seq;
                    unf_d = 1'b1;
                end else begin
                    pc_d     = stack_q[pop_idx];
                    sp_d     = sp_q - SP_ONE;
                    redirect = 1'b1;
                end
            end else if (decoded_call) begin
                if (sp_q == SP_FULL) begin
                    pc_d  = seq;
                    ovf_d = 1'b1;
                end else begin
                    pc_d     = imm_abs;
                    sp_d     = sp_q + SP_ONE;
                    push     = 1'b1;
                    redirect = 1'b1;
                end
            end else if (decoded_pc_mux) begin
                if ((nzp_q & decoded_nzp) != 3'b000) begin
                    pc_d     = decoded_pc_rel ? rel_tgt : imm_abs;
                    redirect = 1'b1;
                end else begin
                    pc_d = seq;
                end
            end else begin
                pc_d = seq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= '0;
            nzp_q <= 3'b000;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            if (is_upd && decoded_nzp_write_enable) begin
                nzp_q <= alu_out[2:0];
            end
        end
    end

    // Stack contents need no reset; depth alone defines validity.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            stack_q[push_idx] <= seq;
        end
    end

`ifdef PC_BRANCH_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 16'h0000;
        end else if (redirect && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign branch_taken_count = cnt_q;
`else
    logic unused_redirect;
    assign unused_redirect = redirect;
`endif

    assign next_pc         = pc_q;
    assign stack_depth     = sp_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: scenario tasks drive instructions into pc_branch_unit,
// push expected {next_pc, depth, ovf, unf} to a queue and compare on output.

module tb_pc_branch_unit;

    typedef struct packed {
        logic [7:0] pc;
        logic [2:0] depth;
        logic       ovf;
        logic       unf;
    } exp_t;

    localparam logic [2:0] ST_IDLE    = 3'b000;
    localparam logic [2:0] ST_EXECUTE = 3'b101;
    localparam logic [2:0] ST_UPDATE  = 3'b110;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] core_state = ST_IDLE;
    logic [2:0] decoded_nzp = 3'b000;
    logic [7:0] decoded_immediate = 8'h00;
    logic       decoded_nzp_write_enable = 1'b0;
    logic       decoded_pc_mux = 1'b0;
    logic       decoded_pc_rel = 1'b0;
    logic       decoded_call = 1'b0;
    logic       decoded_ret = 1'b0;
    logic [7:0] alu_out = 8'h00;
    logic [7:0] current_pc = 8'h00;
    logic [7:0] next_pc;
    logic [2:0] stack_depth;
    logic       stack_overflow;
    logic       stack_underflow;
`ifdef PC_BRANCH_CNT_EN
    logic [15:0] branch_taken_count;
`endif

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    pc_branch_unit #(
        .DATA_MEM_DATA_BITS(8),
        .PROGRAM_MEM_ADDR_BITS(8),
        .STACK_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .core_state(core_state),
        .decoded_nzp(decoded_nzp),
        .decoded_immediate(decoded_immediate),
        .decoded_nzp_write_enable(decoded_nzp_write_enable),
        .decoded_pc_mux(decoded_pc_mux),
        .decoded_pc_rel(decoded_pc_rel),
        .decoded_call(decoded_call),
        .decoded_ret(decoded_ret),
        .alu_out(alu_out),
        .current_pc(current_pc),
        .next_pc(next_pc),
        .stack_depth(stack_depth),
        .stack_overflow(stack_overflow),
`ifdef PC_BRANCH_CNT_EN
        .stack_underflow(stack_underflow),
        .branch_taken_count(branch_taken_count)
`else
        .stack_underflow(stack_underflow)
`endif
    );

    function automatic exp_t observed();
        return {next_pc, stack_depth, stack_overflow, stack_underflow};
    endfunction

    task automatic clear_decode();
        core_state = ST_IDLE;
        decoded_nzp = 3'b000;
        decoded_immediate = 8'h00;
        decoded_nzp_write_enable = 1'b0;
        decoded_pc_mux = 1'b0;
        decoded_pc_rel = 1'b0;
        decoded_call = 1'b0;
        decoded_ret = 1'b0;
        alu_out = 8'h00;
    endtask

    // Drive one EXECUTE cycle; returns #1 after the active edge.
    task automatic exec(input logic [7:0] pc, input logic [7:0] imm,
                        input logic [2:0] mask, input logic mux,
                        input logic rel, input logic call, input logic ret);
        core_state = ST_EXECUTE;
        current_pc = pc;
        decoded_immediate = imm;
        decoded_nzp = mask;
        decoded_pc_mux = mux;
        decoded_pc_rel = rel;
        decoded_call = call;
        decoded_ret = ret;
        @(posedge clk);
        #1;
        clear_decode();
    endtask

    task automatic update(input logic we, input logic [7:0] alu);
        core_state = ST_UPDATE;
        decoded_nzp_write_enable = we;
        alu_out = alu;
        @(posedge clk);
        #1;
        clear_decode();
    endtask

    task automatic idle(input logic [7:0] pc);
        core_state = ST_IDLE;
        current_pc = pc;
        decoded_call = 1'b1;
        decoded_pc_mux = 1'b1;
        decoded_nzp = 3'b111;
        @(posedge clk);
        #1;
        clear_decode();
    endtask

    task automatic test_reset();
        exp_t e, got;
        clear_decode();
        reset = 1'b1;
        sb.push_back('{pc: 8'h00, depth: 3'd0, ovf: 1'b0, unf: 1'b0});
        exec(8'h33, 8'h77, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0);
        got = observed();
        e = sb.pop_front();
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL reset got=%h exp=%h", got, e);
        end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        exp_t e, got;
        logic [7:0] pcs [3];
        pcs = '{8'h05, 8'hFF, 8'h7E};
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{pc: pcs[i] + 8'h01, depth: 3'd0, ovf: 1'b0, unf: 1'b0});
            exec(pcs[i], 8'hAA, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
            got = observed();
            e = sb.pop_front();
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL seq[%0d] got=%h exp=%h", i, got, e);
            end
        end
        // Non-EXECUTE states must hold every register.
        sb.push_back('{pc: 8'h7F, depth: 3'd0, ovf: 1'b0, unf: 1'b0});
        idle(8'h10);
        idle(8'h11);
        got = observed();
        e = sb.pop_front();
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL hold got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_branch_abs();
        exp_t e, got;
        logic [2:0] masks [5];
        logic [7:0] exps  [5];
        update(1'b1, 8'h02);
        // Update without write enable must not disturb NZP=010.
        update(1'b0, 8'h04);
        masks = '{3'b010, 3'b101, 3'b000, 3'b111, 3'b100};
        exps  = '{8'h40, 8'h21, 8'h21, 8'h40, 8'h21};
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{pc: exps[i], depth: 3'd0, ovf: 1'b0, unf: 1'b0});
            exec(8'h20, 8'h40, masks[i], 1'b1, 1'b0, 1'b0, 1'b0);
            got = observed();
            e = sb.pop_front();
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL br_abs[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_branch_rel();
        exp_t e, got;
        logic [7:0] pcs  [3];
        logic [7:0] imms [3];
        logic [7:0] exps [3];
        update(1'b1, 8'hF1);
        pcs  = '{8'h10, 8'h10, 8'hFF};
        imms = '{8'hFC, 8'h05, 8'h01};
        exps = '{8'h0D, 8'h16, 8'h01};
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{pc: exps[i], depth: 3'd0, ovf: 1'b0, unf: 1'b0});
            exec(pcs[i], imms[i], 3'b001, 1'b1, 1'b1, 1'b0, 1'b0);
            got = observed();
            e = sb.pop_front();
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL br_rel[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_call_ret();
        exp_t e, got;
        for (int i = 1; i <= 4; i++) begin
            sb.push_back('{pc: 8'h80, depth: 3'(i), ovf: 1'b0, unf: 1'b0});
            exec(8'(i), 8'h80, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
            got = observed();
            e = sb.pop_front();
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL call[%0d] got=%h exp=%h", i, got, e);
            end
        end
        sb.push_back('{pc: 8'h21, depth: 3'd4, ovf: 1'b1, unf: 1'b0});
        exec(8'h20, 8'h80, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        got = observed();
        e = sb.pop_front();
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL call_full got=%h exp=%h", got, e);
        end
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{pc: 8'(5 - i), depth: 3'(3 - i), ovf: 1'b1, unf: 1'b0});
            exec(8'h80, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
            got = observed();
            e = sb.pop_front();
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL ret[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_underflow();
        exp_t e, got;
        sb.push_back('{pc: 8'h31, depth: 3'd0, ovf: 1'b1, unf: 1'b1});
        exec(8'h30, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        got = observed();
        e = sb.pop_front();
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL ret_empty got=%h exp=%h", got, e);
        end
        sb.push_back('{pc: 8'h32, depth: 3'd0, ovf: 1'b1, unf: 1'b1});
        exec(8'h31, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        got = observed();
        e = sb.pop_front();
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL unf_sticky got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, got;
        // CALL beats a taken branch.
        sb.push_back('{pc: 8'h50, depth: 3'd1, ovf: 1'b1, unf: 1'b1});
        exec(8'h08, 8'h50, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0);
        got = observed();
        e = sb.pop_front();
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL call_prio got=%h exp=%h", got, e);
        end
        sb.push_back('{pc: 8'h09, depth: 3'd0, ovf: 1'b1, unf: 1'b1});
        exec(8'h50, 8'h60, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
        got = observed();
        e = sb.pop_front();
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL call_ret got=%h exp=%h", got, e);
        end
        sb.push_back('{pc: 8'h70, depth: 3'd1, ovf: 1'b1, unf: 1'b1});
        exec(8'h0A, 8'h70, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        got = observed();
        e = sb.pop_front();
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL call_again got=%h exp=%h", got, e);
        end
        reset = 1'b1;
        sb.push_back('{pc: 8'h00, depth: 3'd0, ovf: 1'b0, unf: 1'b0});
        exec(8'h70, 8'h90, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        got = observed();
        e = sb.pop_front();
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL reset_exec got=%h exp=%h", got, e);
        end
        // NZP was cleared by reset: an all-mask branch must not be taken.
        sb.push_back('{pc: 8'h41, depth: 3'd0, ovf: 1'b0, unf: 1'b0});
        exec(8'h40, 8'hC0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
        got = observed();
        e = sb.pop_front();
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL nzp_reset got=%h exp=%h", got, e);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_branch_abs();
        test_branch_rel();
        test_call_ret();
        test_underflow();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
